// File: rtl/upc_pkg.sv
// Shared definitions for the micro-program sequencer: op encoding and op width.
package upc_pkg;
  localparam int UPC_OP_W = 3;

  // Codes 6 and 7 are reserved and execute as HOLD.
  typedef enum logic [UPC_OP_W-1:0] {
    INCR = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    BR_C = 3'd3,
    CALL = 3'd4,
    RET  = 3'd5
  } upc_op_e;
endpackage

// File: rtl/upc_seq_if.sv
// Control-ROM side bundle of the sequencer: op/cond/target in, upc and stack status out.
interface upc_seq_if
  import upc_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) ();
  upc_op_e         op;
  logic            cond;
  logic [AW-1:0]   target;
  logic [AW-1:0]   upc;
  logic [CW-1:0]   sp;
  logic            stack_full;
  logic            stack_empty;
  logic            err;

  modport master (
    output op, cond, target,
    input  upc, sp, stack_full, stack_empty, err
  );

  modport slave (
    input  op, cond, target,
    output upc, sp, stack_full, stack_empty, err
  );
endinterface

// File: rtl/upc_stack.sv
// LIFO return-address stack; push when full and pop when empty are ignored.
module upc_stack #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [CW-1:0] sp,
  output logic          full,
  output logic          empty
);
  logic [CW-1:0] sp_reg;
  logic [CW-1:0] sp_next;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] entry_q [DEPTH];

  assign full    = (sp_reg == CW'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign do_push = push && !full;
  // Push wins if both are requested; the sequencer never asks for both.
  assign do_pop  = pop && !empty && !push;
  assign sp      = sp_reg;

  always_comb begin
    sp_next = sp_reg;
    if (do_push)
      sp_next = sp_reg + CW'(1);
    else if (do_pop)
      sp_next = sp_reg - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sp_reg <= '0;
    else
      sp_reg <= sp_next;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] entry_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        entry_reg <= '0;
      else if (do_push && (sp_reg == CW'(gi)))
        entry_reg <= din;
    end

    assign entry_q[gi] = entry_reg;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_reg == CW'(i + 1))
        dout = entry_q[i];
    end
  end
endmodule

// File: rtl/upc_seq.sv
// Micro-program sequencer: micro-PC with load/increment/branch/call/return and sticky stack error.
module upc_seq
  import upc_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic       clk,
  input logic       reset,
  upc_seq_if.slave  bus
);
  logic [AW-1:0] upc_reg;
  logic [AW-1:0] upc_next;
  logic [AW-1:0] upc_inc;
  logic [AW-1:0] stack_dout;
  logic [CW-1:0] stack_sp;
  logic          stack_full;
  logic          stack_empty;
  logic          push;
  logic          pop;
  logic          overflow;
  logic          underflow;
  logic          err_reg;
  logic          err_next;

  assign upc_inc = upc_reg + AW'(1);

  // Overflow and underflow both freeze upc and the stack; only err moves.
  always_comb begin
    upc_next  = upc_reg;
    push      = 1'b0;
    pop       = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    case (bus.op)
      INCR: upc_next = upc_inc;
      LOAD: upc_next = bus.target;
      HOLD: upc_next = upc_reg;
      BR_C: upc_next = bus.cond ? bus.target : upc_inc;
      CALL: begin
        if (stack_full) begin
          overflow = 1'b1;
        end else begin
          push     = 1'b1;
          upc_next = bus.target;
        end
      end
      RET: begin
        if (stack_empty) begin
          underflow = 1'b1;
        end else begin
          pop      = 1'b1;
          upc_next = stack_dout;
        end
      end
      default: upc_next = upc_reg;
    endcase
  end

  assign err_next = err_reg | overflow | underflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      upc_reg <= upc_next;
      err_reg <= err_next;
    end
  end

  upc_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .dout  (stack_dout),
    .sp    (stack_sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign bus.upc         = upc_reg;
  assign bus.sp          = stack_sp;
  assign bus.stack_full  = stack_full;
  assign bus.stack_empty = stack_empty;
  assign bus.err         = err_reg;
endmodule

// File: tb/tb_upc_seq.sv
// Directed, table-driven bench for upc_seq with AW=5, DEPTH=4.
module tb_upc_seq;
  import upc_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    upc_op_e       op;
    logic          cond;
    logic [AW-1:0] target;
    int            exp_upc;
    int            exp_sp;
    int            exp_err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  upc_seq_if #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) bus ();

  upc_seq #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int e_upc, input int e_sp, input int e_err);
    $display("%s: op=%0d cond=%0d target=%0d -> upc=%0d sp=%0d full=%0d empty=%0d err=%0d",
             tag, bus.op, bus.cond, bus.target, bus.upc, bus.sp,
             bus.stack_full, bus.stack_empty, bus.err);
    chk({tag, " upc"},   int'(bus.upc), e_upc);
    chk({tag, " sp"},    int'(bus.sp), e_sp);
    chk({tag, " err"},   int'(bus.err), e_err);
    chk({tag, " full"},  int'(bus.stack_full), (e_sp == DEPTH) ? 1 : 0);
    chk({tag, " empty"}, int'(bus.stack_empty), (e_sp == 0) ? 1 : 0);
  endtask

  // Drive on the falling edge, let one rising edge execute, sample 1 time unit later.
  task automatic step(input upc_op_e op, input logic cond, input logic [AW-1:0] target);
    @(negedge clk);
    bus.op     = op;
    bus.cond   = cond;
    bus.target = target;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.op = HOLD;
    reset  = 1'b1;
    #1;
    check_state("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    bus.op     = HOLD;
    bus.cond   = 1'b0;
    bus.target = '0;

    // Branch / hold / reserved ops, then nested call and return from upc=7.
    tbl.push_back('{LOAD, 1'b0, 5'd12, 12, 0, 0});
    tbl.push_back('{BR_C, 1'b0, 5'd3,  13, 0, 0});
    tbl.push_back('{BR_C, 1'b1, 5'd3,   3, 0, 0});
    tbl.push_back('{HOLD, 1'b1, 5'd9,   3, 0, 0});
    tbl.push_back('{upc_op_e'(3'd6), 1'b1, 5'd9, 3, 0, 0});
    tbl.push_back('{upc_op_e'(3'd7), 1'b0, 5'd9, 3, 0, 0});
    tbl.push_back('{INCR, 1'b1, 5'd20,  4, 0, 0});
    tbl.push_back('{LOAD, 1'b0, 5'd7,   7, 0, 0});
    tbl.push_back('{CALL, 1'b1, 5'd20, 20, 1, 0});
    tbl.push_back('{CALL, 1'b0, 5'd25, 25, 2, 0});
    tbl.push_back('{RET,  1'b1, 5'd0,  21, 1, 0});
    tbl.push_back('{RET,  1'b0, 5'd0,   8, 0, 0});
    // Fill the stack from upc=0, overflow once, then unwind.
    tbl.push_back('{LOAD, 1'b0, 5'd0,   0, 0, 0});
    tbl.push_back('{CALL, 1'b0, 5'd10, 10, 1, 0});
    tbl.push_back('{CALL, 1'b0, 5'd10, 10, 2, 0});
    tbl.push_back('{CALL, 1'b0, 5'd10, 10, 3, 0});
    tbl.push_back('{CALL, 1'b0, 5'd10, 10, 4, 0});
    tbl.push_back('{CALL, 1'b0, 5'd10, 10, 4, 1});
    tbl.push_back('{RET,  1'b0, 5'd0,  11, 3, 1});
    tbl.push_back('{RET,  1'b0, 5'd0,  11, 2, 1});
    tbl.push_back('{RET,  1'b0, 5'd0,  11, 1, 1});
    tbl.push_back('{RET,  1'b0, 5'd0,   1, 0, 1});
    tbl.push_back('{BR_C, 1'b1, 5'd30, 30, 0, 1});
    tbl.push_back('{INCR, 1'b0, 5'd0,  31, 0, 1});

    do_reset();

    // 33 increments: wrap to 0 on the 32nd edge, 1 after the 33rd.
    for (int i = 1; i <= 33; i++) begin
      step(INCR, 1'b1, 5'd17);
      check_state($sformatf("incr%0d", i), i % 32, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].op, tbl[i].cond, tbl[i].target);
      check_state($sformatf("vec%0d", i), tbl[i].exp_upc, tbl[i].exp_sp, tbl[i].exp_err);
    end

    // Underflow straight out of reset, then a legal op with err still set.
    do_reset();
    step(RET, 1'b0, 5'd4);
    check_state("underflow", 0, 0, 1);
    step(LOAD, 1'b0, 5'd9);
    check_state("load_after_err", 9, 0, 1);

    // Asynchronous reset between edges with two frames on the stack.
    do_reset();
    step(LOAD, 1'b0, 5'd0);
    step(CALL, 1'b0, 5'd5);
    step(CALL, 1'b0, 5'd17);
    check_state("pre_async", 17, 2, 0);
    @(negedge clk);
    bus.op     = CALL;
    bus.target = 5'd30;
    #2;
    reset = 1'b1;
    #1;
    check_state("async_reset", 0, 0, 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_async_call", 30, 1, 0);
    step(RET, 1'b0, 5'd0);
    check_state("post_async_ret", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
